// File: rtl/dds_line_sequencer.sv
// DDS line sequencer: phase accumulator driving a quarter-wave sine ROM,
// with burst/stop control and valid/done flags aligned to the converter output.
module dds_line_sequencer #(
    parameter int PHASE_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   freq_load,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [15:0]            burst_len,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic                   sym_out,
    output logic                   data_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int DW = $clog2(ROM_LATENCY + 3);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] freq_q, freq_d;
    logic [15:0]            count_q, count_d;
    logic [15:0]            len_q, len_d;
    logic                   rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                   sign_q, sign_d;
    logic [ROM_LATENCY-1:0] sym_pipe_q, sym_pipe_d;
    logic [ROM_LATENCY:0]   vld_pipe_q, vld_pipe_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [1:0]             quad;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [15:0]            count_inc;

    assign quad      = phase_q[PHASE_WIDTH-1 -: 2];
    assign idx       = phase_q[PHASE_WIDTH-3 -: ADDR_WIDTH];
    assign count_inc = count_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        freq_d     = freq_load ? freq_word : freq_q;
        count_d    = count_q;
        len_d      = len_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        sign_d     = sign_q;
        drain_d    = drain_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    phase_d = '0;
                    count_d = '0;
                    len_d   = burst_len;
                end
            end
            RUN: begin
                if (stop) begin
                    // A sample issued last cycle is already one stage deeper, so it drains one edge sooner.
                    state_d = DRAIN;
                    drain_d = rom_en_q ? DW'(ROM_LATENCY) : DW'(ROM_LATENCY + 1);
                end else begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = quad[0] ? ~idx : idx;
                    sign_d     = quad[1];
                    phase_d    = phase_q + freq_q;
                    count_d    = count_inc;
                    if (len_q != 16'd0 && count_inc == len_q) begin
                        state_d = DRAIN;
                        drain_d = DW'(ROM_LATENCY + 1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Sign travels alongside the ROM read; valid trails rom_en through ROM plus converter.
    always_comb begin
        sym_pipe_d    = sym_pipe_q;
        sym_pipe_d[0] = sign_q;
        for (int i = 1; i < ROM_LATENCY; i++) sym_pipe_d[i] = sym_pipe_q[i-1];
        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = rom_en_q;
        for (int i = 1; i <= ROM_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            freq_q     <= '0;
            count_q    <= '0;
            len_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            sign_q     <= 1'b0;
            sym_pipe_q <= '0;
            vld_pipe_q <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            freq_q     <= freq_d;
            count_q    <= count_d;
            len_q      <= len_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            sign_q     <= sign_d;
            sym_pipe_q <= sym_pipe_d;
            vld_pipe_q <= vld_pipe_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign sym_out    = sym_pipe_q[ROM_LATENCY-1];
    assign data_valid = vld_pipe_q[ROM_LATENCY];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dds_line_sequencer.sv
// Directed bench for dds_line_sequencer at default parameters (idx = phase[13:6]).
module tb_dds_line_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0, stop = 1'b0, freq_load = 1'b0;
    logic [15:0] freq_word = '0, burst_len = '0;
    logic        rom_en, sym_out, data_valid, busy, done;
    logic [7:0]  rom_addr;

    dds_line_sequencer dut (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop),
        .freq_load(freq_load), .freq_word(freq_word), .burst_len(burst_len),
        .rom_en(rom_en), .rom_addr(rom_addr), .sym_out(sym_out),
        .data_valid(data_valid), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    int edge_n, n_en, n_dv, n_done, done_edge, first_en, first_dv, last_en;
    bit prev_en, dv_at_done, busy_at_done;
    logic [7:0] addr_q[$];
    bit sym_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        edge_n = 0; n_en = 0; n_dv = 0; n_done = 0; done_edge = -1;
        first_en = -1; first_dv = -1; last_en = -1;
        prev_en = 1'b0; dv_at_done = 1'b0; busy_at_done = 1'b0;
        addr_q.delete(); sym_q.delete();
    endtask

    // One clock; observe 1 time unit after the edge and log what it produced.
    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
        if (rom_en) begin
            addr_q.push_back(rom_addr);
            n_en++;
            last_en = edge_n;
            if (first_en < 0) first_en = edge_n;
        end
        if (prev_en) sym_q.push_back(sym_out);
        prev_en = rom_en;
        if (data_valid) begin
            n_dv++;
            if (first_dv < 0) first_dv = edge_n;
        end
        if (done) begin
            n_done++;
            done_edge = edge_n;
            dv_at_done = data_valid;
            busy_at_done = busy;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_freq(logic [15:0] w);
        freq_word = w; freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
    endtask

    task automatic chk_addr(string tag, int i, int exp);
        logic [31:0] v;
        v = (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF_FFFF;
        chk($sformatf("%s_addr%0d", tag, i), v, exp);
    endtask

    task automatic chk_sym(string tag, int i, bit exp);
        logic [31:0] v;
        v = (i < sym_q.size()) ? 32'(sym_q[i]) : 32'hFFFF_FFFF;
        chk($sformatf("%s_sym%0d", tag, i), v, 32'(exp));
    endtask

    task automatic start_burst(logic [15:0] len);
        clear_log();
        burst_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_sym", sym_out, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        RESET = 1'b1;

        // 1: ramp of four addresses, timing of first issue / valid / done
        load_freq(16'h0040);
        start_burst(16'd4);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_en_after_start", rom_en, 0);
        ticks(8);
        for (int i = 0; i < 4; i++) chk_addr("t1", i, i);
        for (int i = 0; i < 4; i++) chk_sym("t1", i, 1'b0);
        chk("t1_n_en", n_en, 4);
        chk("t1_first_en", first_en, 2);
        chk("t1_first_dv", first_dv, 4);
        chk("t1_n_dv", n_dv, 4);
        chk("t1_n_done", n_done, 1);
        chk("t1_done_edge", done_edge, last_en + 3);
        chk("t1_dv_at_done", dv_at_done, 0);
        chk("t1_busy_at_done", busy_at_done, 0);

        // 2: quadrant walk exercises mirror and sign
        load_freq(16'h4000);
        start_burst(16'd4);
        ticks(8);
        for (int i = 0; i < 4; i++) chk_addr("t2", i, (i % 2) ? 255 : 0);
        for (int i = 0; i < 4; i++) chk_sym("t2", i, i >= 2);
        chk("t2_n_done", n_done, 1);

        // 3: continuous run, stop after 10 samples, start during DRAIN ignored
        load_freq(16'h0040);
        start_burst(16'd0);
        ticks(10);
        stop = 1'b1;
        tick();
        stop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ticks(6);
        chk("t3_n_en", n_en, 10);
        chk("t3_n_dv", n_dv, 10);
        for (int i = 0; i < 10; i++) chk_addr("t3", i, i);
        chk("t3_last_en", last_en, 11);
        chk("t3_done_edge", done_edge, 14);
        chk("t3_n_done", n_done, 1);
        chk("t3_busy_end", busy, 0);

        // 4: increment reloaded mid-burst (sampled on the 2nd issue edge) takes effect on the next sample
        load_freq(16'h0040);
        start_burst(16'd6);
        tick();
        freq_word = 16'h0080; freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
        ticks(8);
        chk_addr("t4", 0, 0);
        chk_addr("t4", 1, 1);
        chk_addr("t4", 2, 2);
        chk_addr("t4", 3, 4);
        chk_addr("t4", 4, 6);
        chk_addr("t4", 5, 8);
        chk("t4_n_en", n_en, 6);

        // 5: asynchronous reset mid-burst, then clean restart
        load_freq(16'h0040);
        start_burst(16'd0);
        ticks(5);
        #3 RESET = 1'b0;
        #1;
        chk("t5_rst_en", rom_en, 0);
        chk("t5_rst_addr", rom_addr, 0);
        chk("t5_rst_dv", data_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_sym", sym_out, 0);
        #1 RESET = 1'b1;
        load_freq(16'h0040);
        start_burst(16'd2);
        ticks(6);
        chk_addr("t5", 0, 0);
        chk_addr("t5", 1, 1);
        chk("t5_n_en", n_en, 2);
        chk("t5_n_done", n_done, 1);

        // 6: start+stop together starts; stop on the final sample suppresses it
        clear_log();
        burst_len = 16'd3; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t6_busy", busy, 1);
        ticks(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(5);
        chk("t6_n_en", n_en, 2);
        chk("t6_n_dv", n_dv, 2);
        chk("t6_n_done", n_done, 1);
        chk("t6_done_edge", done_edge, 6);

        // 7: stop before any sample issued
        start_burst(16'd4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        ticks(5);
        chk("t7_n_en", n_en, 0);
        chk("t7_n_dv", n_dv, 0);
        chk("t7_done_edge", done_edge, 5);
        chk("t7_n_done", n_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
